// File: rtl/duc_pkg.sv
// Shared definitions for the transmit up-converter: FSM encoding, default NCO word,
// and the saturating negate used by the quadrant mixer.
package duc_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPrime = 2'd1,
      StRun   = 2'd2,
      StDrain = 2'd3
   } duc_state_e;

   localparam logic [27:0] FCW_50M = 28'h4000000;

   // Two's-complement negate that clamps -32768 to +32767 instead of wrapping.
   function automatic logic [15:0] sat_neg(input logic [15:0] x);
      if (x == 16'h8000) begin
         return 16'h7fff;
      end
      return (~x) + 16'd1;
   endfunction

endpackage

// File: rtl/duc_fifo.sv
// Synchronous FIFO with occupancy output and a synchronous flush.
// Depth must be a power of two so the pointers wrap naturally.
module duc_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rptr];

   // A push into a full FIFO is legal when the same cycle also pops.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/duc_iq.sv
// Transmit DUC: buffers baseband I/Q, zero-order-holds each sample for INTERP cycles and
// mixes it to a real IF with a quadrant NCO. Exports the held baseband for loopback.
module duc_iq
   import duc_pkg::*;
#(
   parameter int unsigned INTERP     = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clk_200m,
   input  logic         cfg_rst,
   input  logic         dac_txenable,
   input  logic [27:0]  fcw_data,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [15:0]  s_i,
   input  logic [15:0]  s_q,
   output logic [15:0]  dac_data,
   output logic         dac_valid,
   output logic [31:0]  loop_data,
   output logic         underflow,
   output logic [127:0] duc_iq_debug
);

   localparam int unsigned LW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0]  CNT_LAST = 4'(INTERP - 1);

   duc_state_e   r_state;
   logic [3:0]   r_cnt;
   logic [27:0]  r_phase;
   logic [15:0]  r_hold_i;
   logic [15:0]  r_hold_q;
   logic [15:0]  r_dac_data;
   logic         r_dac_valid;
   logic [31:0]  r_loop_data;
   logic         r_underflow;

   logic         w_push;
   logic         w_pop;
   logic         w_flush;
   logic         w_full;
   logic         w_empty;
   logic [LW-1:0] w_level;
   logic [31:0]  w_head;
   logic         w_go;
   logic         w_last;
   logic [15:0]  w_mix;

   assign s_ready = !cfg_rst && (r_state != StDrain) && !w_full;
   assign w_push  = s_valid && s_ready;
   assign w_go    = (w_level >= LW'(2)) || w_full;
   assign w_last  = (r_cnt == CNT_LAST);
   assign w_flush = (r_state == StDrain);
   assign w_pop   = dac_txenable && (((r_state == StPrime) && w_go) ||
                                     ((r_state == StRun) && w_last));

   duc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .i_clk   (clk_200m),
      .i_rst   (cfg_rst),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_wdata ({s_i, s_q}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Quadrant mixer: multiply by cos/sin sampled at 0, 90, 180, 270 degrees.
   always_comb begin
      w_mix = r_hold_i;
      unique case (r_phase[27:26])
         2'd0: w_mix = r_hold_i;
         2'd1: w_mix = sat_neg(r_hold_q);
         2'd2: w_mix = sat_neg(r_hold_i);
         2'd3: w_mix = r_hold_q;
      endcase
   end

   always_ff @(posedge clk_200m) begin
      if (cfg_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_phase     <= '0;
         r_hold_i    <= '0;
         r_hold_q    <= '0;
         r_dac_data  <= '0;
         r_dac_valid <= 1'b0;
         r_loop_data <= '0;
         r_underflow <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_phase     <= '0;
               r_cnt       <= '0;
               r_dac_data  <= '0;
               r_dac_valid <= 1'b0;
               r_loop_data <= '0;
               if (dac_txenable) begin
                  r_state <= StPrime;
               end
            end
            StPrime: begin
               r_dac_data  <= '0;
               r_dac_valid <= 1'b0;
               r_loop_data <= '0;
               if (!dac_txenable) begin
                  r_state <= StIdle;
               end else if (w_go) begin
                  r_state  <= StRun;
                  r_hold_i <= w_head[31:16];
                  r_hold_q <= w_head[15:0];
                  r_phase  <= '0;
                  r_cnt    <= '0;
               end
            end
            StRun: begin
               r_dac_data  <= w_mix;
               r_dac_valid <= 1'b1;
               r_loop_data <= {r_hold_i, r_hold_q};
               if (!dac_txenable) begin
                  r_state <= StDrain;
                  r_cnt   <= '0;
               end else begin
                  r_phase <= r_phase + fcw_data;
                  r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
                  if (w_last) begin
                     if (w_empty) begin
                        r_hold_i    <= '0;
                        r_hold_q    <= '0;
                        r_underflow <= 1'b1;
                     end else begin
                        r_hold_i <= w_head[31:16];
                        r_hold_q <= w_head[15:0];
                     end
                  end
               end
            end
            StDrain: begin
               r_dac_data  <= '0;
               r_dac_valid <= 1'b1;
               r_loop_data <= '0;
               r_cnt       <= w_last ? 4'd0 : r_cnt + 4'd1;
               if (w_last) begin
                  r_state <= StIdle;
               end
            end
         endcase
      end
   end

   assign dac_data  = r_dac_data;
   assign dac_valid = r_dac_valid;
   assign loop_data = r_loop_data;
   assign underflow = r_underflow;

   assign duc_iq_debug = {r_state, r_cnt, 5'(w_level), r_phase, r_hold_i, r_hold_q,
                          r_dac_data, 41'd0};

endmodule

// File: tb/tb_duc_iq.sv
// Directed bench for duc_iq (INTERP=4, FIFO_DEPTH=4): mixing, saturation, underflow,
// reset mid-run, backpressure ordering and drain.
module tb_duc_iq;
   import duc_pkg::*;

   logic         clk_200m;
   logic         cfg_rst;
   logic         dac_txenable;
   logic [27:0]  fcw_data;
   logic         s_valid;
   logic         s_ready;
   logic [15:0]  s_i;
   logic [15:0]  s_q;
   logic [15:0]  dac_data;
   logic         dac_valid;
   logic [31:0]  loop_data;
   logic         underflow;
   logic [127:0] duc_iq_debug;

   int n_chk = 0;
   int n_err = 0;

   logic [1:0] dbg_state;
   logic [4:0] dbg_level;
   assign dbg_state = duc_iq_debug[127:126];
   assign dbg_level = duc_iq_debug[121:117];

   duc_iq #(
      .INTERP     (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_200m     (clk_200m),
      .cfg_rst      (cfg_rst),
      .dac_txenable (dac_txenable),
      .fcw_data     (fcw_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_i          (s_i),
      .s_q          (s_q),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid),
      .loop_data    (loop_data),
      .underflow    (underflow),
      .duc_iq_debug (duc_iq_debug)
   );

   initial clk_200m = 1'b0;
   always #5 clk_200m = ~clk_200m;

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk_200m);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Backpressure ramp: sample v carries I=v, Q=v+500; four quadrant outputs per sample.
   function automatic logic [15:0] bp_exp(input int m);
      int v;
      v = m / 4;
      case (m % 4)
         0:       return 16'(v);
         1:       return 16'(-(v + 500));
         2:       return 16'(-v);
         default: return 16'(v + 500);
      endcase
   endfunction

   logic [15:0] exp_a [8];
   int  m;
   int  nacc;
   int  v;
   logic acc;

   initial begin
      exp_a = '{16'd1000, 16'hFF38, 16'hFC18, 16'd200,
                16'd300,  16'hFE70, 16'hFED4, 16'd400};
      cfg_rst      = 1'b1;
      dac_txenable = 1'b0;
      fcw_data     = FCW_50M;
      s_valid      = 1'b0;
      s_i          = '0;
      s_q          = '0;
      step(2);

      chk("rst_ready",     32'(s_ready),   32'd0);
      chk("rst_dac_data",  32'(dac_data),  32'd0);
      chk("rst_dac_valid", 32'(dac_valid), 32'd0);
      chk("rst_loop",      loop_data,      32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_state",     32'(dbg_state), 32'd0);
      chk("rst_level",     32'(dbg_level), 32'd0);

      // Basic mixing followed by underflow
      cfg_rst = 1'b0;
      #1;
      chk("idle_ready", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_i = 16'd1000; s_q = 16'd200;
      step();
      s_i = 16'd300; s_q = 16'd400;
      step();
      s_valid = 1'b0; dac_txenable = 1'b1;
      chk("idle_level2", 32'(dbg_level), 32'd2);
      chk("idle_state",  32'(dbg_state), 32'd0);
      step();
      chk("prime_state", 32'(dbg_state), 32'd1);
      step();
      chk("run_state",       32'(dbg_state), 32'd2);
      chk("run_first_valid", 32'(dac_valid), 32'd0);
      chk("run_level",       32'(dbg_level), 32'd1);
      step();
      for (int k = 0; k < 8; k++) begin
         chk("mix_data",  32'(dac_data),  32'(exp_a[k]));
         chk("mix_valid", 32'(dac_valid), 32'd1);
         chk("mix_uflow", 32'(underflow), (k == 7) ? 32'd1 : 32'd0);
         if (k == 0) chk("mix_loop", loop_data, {16'd1000, 16'd200});
         step();
      end
      chk("uf_zero_data",  32'(dac_data),  32'd0);
      chk("uf_zero_valid", 32'(dac_valid), 32'd1);
      chk("uf_zero_loop",  loop_data,      32'd0);

      // Saturation sample pushed while running; underflow stays sticky
      s_valid = 1'b1; s_i = 16'h8000; s_q = 16'h8000;
      step();
      s_valid = 1'b0;
      step(2);
      chk("sticky_uflow", 32'(underflow), 32'd1);
      chk("sat_popped",   32'(dbg_level), 32'd0);
      step();
      chk("sat_q0", 32'(dac_data), 32'h8000);
      step();
      chk("sat_q1", 32'(dac_data), 32'h7fff);
      step();
      chk("sat_q2", 32'(dac_data), 32'h7fff);
      s_valid = 1'b1; s_i = 16'd7; s_q = 16'd8;
      step();
      chk("sat_q3",       32'(dac_data),  32'h8000);
      chk("pre_rst_level", 32'(dbg_level), 32'd1);

      // Reset mid-run
      s_valid = 1'b0; cfg_rst = 1'b1; dac_txenable = 1'b0;
      step();
      chk("mr_data",  32'(dac_data),  32'd0);
      chk("mr_valid", 32'(dac_valid), 32'd0);
      chk("mr_loop",  loop_data,      32'd0);
      chk("mr_uflow", 32'(underflow), 32'd0);
      chk("mr_state", 32'(dbg_state), 32'd0);
      chk("mr_level", 32'(dbg_level), 32'd0);
      chk("mr_ready", 32'(s_ready),   32'd0);
      cfg_rst = 1'b0;
      #1;
      chk("mr_ready_after", 32'(s_ready), 32'd1);

      // Backpressure: fill in IDLE, then one accept per INTERP cycles in RUN
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_i = 16'(i); s_q = 16'(i + 500);
         chk("bp_fill_ready", 32'(s_ready), 32'd1);
         step();
      end
      v = 4; s_i = 16'(v); s_q = 16'(v + 500);
      chk("bp_full_ready", 32'(s_ready),   32'd0);
      chk("bp_full_level", 32'(dbg_level), 32'd4);
      dac_txenable = 1'b1;
      m = 0; nacc = 0;
      for (int c = 0; c < 24; c++) begin
         if (dac_valid) begin
            chk("bp_out", 32'(dac_data), 32'(bp_exp(m)));
            m++;
         end
         acc = s_ready;
         step();
         if (acc) begin
            nacc++;
            v++;
            s_i = 16'(v); s_q = 16'(v + 500);
         end
      end
      chk("bp_accepts", 32'(nacc), 32'd6);
      chk("bp_outputs", 32'(m),    32'd21);
      chk("bp_uflow",   32'(underflow), 32'd0);

      // Disable and drain
      s_valid = 1'b0; dac_txenable = 1'b0;
      step();
      chk("dr_last_mix_valid", 32'(dac_valid), 32'd1);
      step();
      chk("dr_state", 32'(dbg_state), 32'd3);
      chk("dr_level", 32'(dbg_level), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("dr_data",  32'(dac_data),  32'd0);
         chk("dr_valid", 32'(dac_valid), 32'd1);
         step();
      end
      chk("dr_end_valid", 32'(dac_valid), 32'd0);
      chk("dr_end_state", 32'(dbg_state), 32'd0);
      chk("dr_end_level", 32'(dbg_level), 32'd0);
      chk("dr_end_ready", 32'(s_ready),   32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
